// File: rtl/npc_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, default reset PC/width,
// and the instruction alignment check used on every redirect.
package npc_pkg;

    localparam int          XLEN_DEF     = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_REQ      = 3'd0,
        ST_WAIT_RSP = 3'd1,
        ST_HOLD     = 3'd2,
        ST_WAIT_NPC = 3'd3,
        ST_FAULT    = 3'd4
    } fetch_state_e;

    // Takes only the two low address bits so it works for any XLEN.
    function automatic logic is_aligned32(input logic [1:0] addr_lo);
        return (addr_lo == 2'b00);
    endfunction

endpackage

// File: rtl/ifu_fetch.sv
// Multicycle instruction fetch unit: one memory read per instruction, result
// held for decode, next fetch launched only when the next PC is supplied.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int               XLEN     = XLEN_DEF,
    parameter logic [XLEN-1:0]  RESET_PC = RESET_PC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            mem_req_valid,
    output logic [XLEN-1:0] mem_req_addr,
    input  logic            mem_req_ready,
    input  logic            mem_rsp_valid,
    input  logic [XLEN-1:0] mem_rsp_data,
    input  logic            mem_rsp_err,
    output logic            IFU_valid,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] pc,
    input  logic            IDU_ready,
    input  logic            npc_valid,
    input  logic [XLEN-1:0] npc,
    output logic            fetch_fault
);

    fetch_state_e    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_inst;
    logic            r_req_valid;
    logic            r_ifu_valid;
    logic            r_fault;

    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] w_pc_nxt;
    logic [XLEN-1:0] w_inst_nxt;
    logic            w_req_nxt;
    logic            w_ifu_nxt;
    logic            w_fault_nxt;
    logic            w_take_npc;

    // Next-state and next-output computation for the fetch FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_inst_nxt  = r_inst;
        w_req_nxt   = r_req_valid;
        w_ifu_nxt   = r_ifu_valid;
        w_fault_nxt = r_fault;
        w_take_npc  = 1'b0;

        case (r_state)
            ST_REQ: begin
                // Request valid is registered, so the first REQ cycle after reset is idle.
                if (r_req_valid && mem_req_ready) begin
                    w_req_nxt   = 1'b0;
                    w_state_nxt = ST_WAIT_RSP;
                end else begin
                    w_req_nxt   = 1'b1;
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    if (mem_rsp_err) begin
                        w_fault_nxt = 1'b1;
                        w_state_nxt = ST_FAULT;
                    end else begin
                        w_inst_nxt  = mem_rsp_data;
                        w_ifu_nxt   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end else begin
                    w_state_nxt = ST_WAIT_RSP;
                end
            end
            ST_HOLD: begin
                if (r_ifu_valid && IDU_ready) begin
                    w_ifu_nxt = 1'b0;
                    if (npc_valid) begin
                        w_take_npc = 1'b1;
                    end else begin
                        w_state_nxt = ST_WAIT_NPC;
                    end
                end else begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_WAIT_NPC: begin
                if (npc_valid) begin
                    w_take_npc = 1'b1;
                end else begin
                    w_state_nxt = ST_WAIT_NPC;
                end
            end
            ST_FAULT: begin
                w_fault_nxt = 1'b1;
                w_req_nxt   = 1'b0;
                w_ifu_nxt   = 1'b0;
            end
            default: begin
                w_state_nxt = ST_FAULT;
                w_fault_nxt = 1'b1;
                w_req_nxt   = 1'b0;
                w_ifu_nxt   = 1'b0;
            end
        endcase

        // A misaligned redirect is still latched into pc so the faulting target is visible.
        if (w_take_npc) begin
            w_pc_nxt = npc;
            if (is_aligned32(npc[1:0])) begin
                w_req_nxt   = 1'b1;
                w_state_nxt = ST_REQ;
            end else begin
                w_fault_nxt = 1'b1;
                w_req_nxt   = 1'b0;
                w_state_nxt = ST_FAULT;
            end
        end else begin
            w_pc_nxt = w_pc_nxt;
        end
    end

    // State and registered output update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_inst      <= '0;
            r_req_valid <= 1'b0;
            r_ifu_valid <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_inst      <= w_inst_nxt;
            r_req_valid <= w_req_nxt;
            r_ifu_valid <= w_ifu_nxt;
            r_fault     <= w_fault_nxt;
        end
    end

    assign mem_req_valid = r_req_valid;
    assign mem_req_addr  = r_pc;
    assign IFU_valid     = r_ifu_valid;
    assign inst          = r_inst;
    assign pc            = r_pc;
    assign fetch_fault   = r_fault;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a flag-based transaction model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_ifu_fetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        mem_rsp_err;
    logic        IFU_valid;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        IDU_ready;
    logic        npc_valid;
    logic [31:0] npc;
    logic        fetch_fault;

    int n_cmp = 0;
    int n_bad = 0;

    ifu_fetch dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .IFU_valid(IFU_valid), .inst(inst), .pc(pc), .IDU_ready(IDU_ready),
        .npc_valid(npc_valid), .npc(npc), .fetch_fault(fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: which obligations are open (request, outstanding read, word held, npc awaited).
    logic        m_req, m_out, m_ifu, m_need, m_fault;
    logic [31:0] m_pc, m_inst;
    logic        n_req, n_out, n_ifu, n_need, n_fault, n_take;
    logic [31:0] n_pc, n_inst;

    always @* begin
        n_req = m_req; n_out = m_out; n_ifu = m_ifu; n_need = m_need;
        n_fault = m_fault; n_pc = m_pc; n_inst = m_inst; n_take = 1'b0;
        if (!m_fault) begin
            if (m_req && mem_req_ready) begin
                n_req = 1'b0;
                n_out = 1'b1;
            end else if (!m_out && !m_ifu && !m_need) begin
                n_req = 1'b1;
            end
            if (m_out && mem_rsp_valid) begin
                if (mem_rsp_err) n_fault = 1'b1;
                else begin
                    n_inst = mem_rsp_data;
                    n_ifu  = 1'b1;
                    n_out  = 1'b0;
                end
            end
            if (m_ifu && IDU_ready) begin
                n_ifu = 1'b0;
                if (npc_valid) n_take = 1'b1;
                else n_need = 1'b1;
            end
            if (m_need && npc_valid) n_take = 1'b1;
            if (n_take) begin
                n_pc   = npc;
                n_need = 1'b0;
                if (npc % 4 != 0) n_fault = 1'b1;
                else n_req = 1'b1;
            end
            if (n_fault) begin
                n_req = 1'b0;
                n_ifu = 1'b0;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req <= 1'b0; m_out <= 1'b0; m_ifu <= 1'b0; m_need <= 1'b0;
            m_fault <= 1'b0; m_pc <= RST_PC; m_inst <= 32'h0;
        end else begin
            m_req <= n_req; m_out <= n_out; m_ifu <= n_ifu; m_need <= n_need;
            m_fault <= n_fault; m_pc <= n_pc; m_inst <= n_inst;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        check("cmp_req_valid", {31'b0, mem_req_valid}, {31'b0, m_req});
        if (m_req) check("cmp_req_addr", mem_req_addr, m_pc);
        check("cmp_ifu_valid", {31'b0, IFU_valid}, {31'b0, m_ifu});
        check("cmp_inst", inst, m_inst);
        check("cmp_pc", pc, m_pc);
        check("cmp_fault", {31'b0, fetch_fault}, {31'b0, m_fault});
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic accept_and_respond(input logic [31:0] data, input logic err);
        mem_req_ready = 1'b1; cyc(); mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = data; mem_rsp_err = err;
        cyc();
        mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        mem_rsp_err = 1'b0; IDU_ready = 1'b0; npc_valid = 1'b0; npc = 32'h0;
        repeat (3) cyc();
        check("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        check("rst_ifu_valid", {31'b0, IFU_valid}, 32'd0);
        check("rst_pc", pc, 32'h8000_0000);
        check("rst_inst", inst, 32'h0);
        check("rst_fault", {31'b0, fetch_fault}, 32'd0);

        // First fetch with a two-cycle response.
        rst_n = 1'b1; cyc();
        check("first_req", {31'b0, mem_req_valid}, 32'd1);
        check("first_addr", mem_req_addr, 32'h8000_0000);
        mem_req_ready = 1'b1; cyc(); mem_req_ready = 1'b0;
        check("req_dropped", {31'b0, mem_req_valid}, 32'd0);
        npc_valid = 1'b1; npc = 32'h1234_5670; cyc(); npc_valid = 1'b0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h0000_0413; cyc(); mem_rsp_valid = 1'b0;
        check("t1_ifu_valid", {31'b0, IFU_valid}, 32'd1);
        check("t1_inst", inst, 32'h0000_0413);
        check("t1_pc", pc, 32'h8000_0000);

        // Decode stall: word held stable; stray response ignored.
        for (int i = 0; i < 5; i++) begin
            mem_rsp_valid = (i == 2); mem_rsp_data = 32'hFFFF_FFFF;
            cyc();
            check("hold_valid", {31'b0, IFU_valid}, 32'd1);
            check("hold_inst", inst, 32'h0000_0413);
            check("hold_pc", pc, 32'h8000_0000);
        end
        mem_rsp_valid = 1'b0;
        IDU_ready = 1'b1; cyc(); IDU_ready = 1'b0;
        check("consumed_valid", {31'b0, IFU_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("wait_npc_noreq", {31'b0, mem_req_valid}, 32'd0);
        end
        npc_valid = 1'b1; npc = 32'h8000_0004; cyc(); npc_valid = 1'b0;
        check("npc_req", {31'b0, mem_req_valid}, 32'd1);
        check("npc_addr", mem_req_addr, 32'h8000_0004);

        // Memory back-pressure: request and address stable; stray npc ignored.
        for (int i = 0; i < 3; i++) begin
            npc_valid = (i == 1); npc = 32'h1234_5678;
            cyc();
            check("bp_req", {31'b0, mem_req_valid}, 32'd1);
            check("bp_addr", mem_req_addr, 32'h8000_0004);
        end
        npc_valid = 1'b0;
        accept_and_respond(32'h0010_0093, 1'b0);
        check("t3_inst", inst, 32'h0010_0093);
        check("t3_pc", pc, 32'h8000_0004);

        // Redirect in the handshake cycle skips the npc wait.
        IDU_ready = 1'b1; npc_valid = 1'b1; npc = 32'h8000_0010; cyc();
        IDU_ready = 1'b0; npc_valid = 1'b0;
        check("bypass_req", {31'b0, mem_req_valid}, 32'd1);
        check("bypass_addr", mem_req_addr, 32'h8000_0010);
        accept_and_respond(32'h0000_0013, 1'b0);
        check("t4_pc", pc, 32'h8000_0010);
        IDU_ready = 1'b1; cyc(); IDU_ready = 1'b0;

        // Misaligned redirect faults and stops fetching.
        npc_valid = 1'b1; npc = 32'h8000_0006; cyc(); npc_valid = 1'b0;
        check("mis_fault", {31'b0, fetch_fault}, 32'd1);
        check("mis_pc", pc, 32'h8000_0006);
        for (int i = 0; i < 4; i++) begin
            mem_req_ready = 1'b1; cyc();
            check("mis_noreq", {31'b0, mem_req_valid}, 32'd0);
        end
        mem_req_ready = 1'b0;

        // Bus error on the response faults likewise.
        rst_n = 1'b0; cyc();
        check("rst2_fault", {31'b0, fetch_fault}, 32'd0);
        check("rst2_pc", pc, 32'h8000_0000);
        rst_n = 1'b1; cyc();
        accept_and_respond(32'h0000_0013, 1'b1);
        check("err_fault", {31'b0, fetch_fault}, 32'd1);
        check("err_ifu", {31'b0, IFU_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("err_noreq", {31'b0, mem_req_valid}, 32'd0);
        end

        // Reset while waiting for a response; the late response is dropped.
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        mem_req_ready = 1'b1; cyc(); mem_req_ready = 1'b0;
        rst_n = 1'b0; cyc(); rst_n = 1'b1; cyc();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_BAD0; cyc(); mem_rsp_valid = 1'b0;
        check("stale_ifu", {31'b0, IFU_valid}, 32'd0);
        check("stale_inst", inst, 32'h0);
        check("stale_req", {31'b0, mem_req_valid}, 32'd1);
        accept_and_respond(32'h00A0_0513, 1'b0);
        check("fresh_ifu", {31'b0, IFU_valid}, 32'd1);
        check("fresh_inst", inst, 32'h00A0_0513);
        check("fresh_pc", pc, 32'h8000_0000);
        IDU_ready = 1'b1; cyc(); IDU_ready = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
